fifo_burst_rd: RTL and testbench

//  Read-side burst controller that sits on the output of a FIFO read port: val/rdy data, empty flag and word count.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_burst_rd.sv | 143 ++++++++++++++
 tb/tb_fifo_burst_rd.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO read-side burst controller
package fifo_pkg;

    typedef enum logic [0:0] {
        FBR_IDLE,
        FBR_BURST
    } fbr_state_t;

    // Width of a FIFO word count able to represent 0..size inclusive.
    function automatic int cnt_bits(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/fifo_burst_rd.sv
// rtl/fifo_burst_rd.sv - FIFO read-side controller that drains whole framed bursts
//
// Waits until BURST_LEN words are buffered in the upstream FIFO, then pops exactly
// that many and presents them downstream as one packet framed by o_sop/o_eop.
// Optional macro FIFO_BURST_RD_TIMEOUT_EN: after TIMEOUT_CYC non-empty idle cycles,
// flush the residual words as a shorter, equally framed burst.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_val, i_dat, o_rdy     FIFO read port (word moves when i_val && o_rdy)
//   i_emp, i_wrds           FIFO empty flag and word count (count valid when ~i_emp)
//   o_val, o_dat, i_rdy     downstream burst stream
//   o_sop, o_eop            first/last beat markers, qualified by o_val
//   o_len                   length of the current burst, stable sop..eop
//   o_busy                  burst in progress
module fifo_burst_rd
    import fifo_pkg::*;
#(
    parameter int DAT_BITS    = 8,
    parameter int CNT_BITS    = cnt_bits(4),
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_val,
    input  logic [DAT_BITS-1:0] i_dat,
    output logic                o_rdy,
    input  logic                i_emp,
    input  logic [CNT_BITS-1:0] i_wrds,
    output logic                o_val,
    output logic [DAT_BITS-1:0] o_dat,
    output logic                o_sop,
    output logic                o_eop,
    output logic [CNT_BITS-1:0] o_len,
    input  logic                i_rdy,
    output logic                o_busy
);

    if (BURST_LEN == 0 || BURST_LEN > 2 ** (CNT_BITS - 1) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $fatal(1, "fifo_burst_rd: BURST_LEN/TIMEOUT_CYC out of range for CNT_BITS");
    end

    localparam logic [CNT_BITS-1:0] BURST_LEN_C = CNT_BITS'(BURST_LEN);

    fbr_state_t          state_q;
    logic [CNT_BITS-1:0] beats_q;
    logic [CNT_BITS-1:0] len_q;
    logic [DAT_BITS-1:0] dat_q;
    logic                val_q;
    logic                sop_q;
    logic                eop_q;

    logic take;
    logic hs_done;
    logic full_go;

    // Pop only when the output register is free or being emptied this cycle;
    // deliberately independent of i_val.
    assign o_rdy   = (state_q == FBR_BURST) && (beats_q != '0) && (!val_q || i_rdy);
    assign take    = o_rdy && i_val;
    assign hs_done = val_q && i_rdy;
    // An under-reporting count only delays the start; the pop limit is beats_q.
    assign full_go = !i_emp && (i_wrds >= BURST_LEN_C);

`ifdef FIFO_BURST_RD_TIMEOUT_EN
    localparam int TMR_BITS = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT_CYC - 1);

    logic [TMR_BITS-1:0] tmr_q;
    logic                tmo_go;

    // A zero count would mean a zero-length burst; keep waiting instead.
    assign tmo_go = !i_emp && (tmr_q == TMR_LAST) && (i_wrds != '0);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= FBR_IDLE;
            beats_q <= '0;
            len_q   <= '0;
            dat_q   <= '0;
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
`ifdef FIFO_BURST_RD_TIMEOUT_EN
            tmr_q   <= '0;
`endif
        end else begin
            case (state_q)
                FBR_IDLE: begin
                    if (full_go) begin
                        state_q <= FBR_BURST;
                        len_q   <= BURST_LEN_C;
                        beats_q <= BURST_LEN_C;
                    end
`ifdef FIFO_BURST_RD_TIMEOUT_EN
                    else if (tmo_go) begin
                        state_q <= FBR_BURST;
                        len_q   <= i_wrds;
                        beats_q <= i_wrds;
                    end
`endif
                end
                FBR_BURST: begin
                    if (take) begin
                        dat_q   <= i_dat;
                        val_q   <= 1'b1;
                        sop_q   <= (beats_q == len_q);
                        eop_q   <= (beats_q == CNT_BITS'(1));
                        beats_q <= beats_q - 1'b1;
                    end else if (hs_done) begin
                        val_q <= 1'b0;
                        sop_q <= 1'b0;
                        eop_q <= 1'b0;
                    end
                    // On the eop handshake beats_q is already 0, so no take can overlap.
                    if (hs_done && eop_q) begin
                        state_q <= FBR_IDLE;
                    end
                end
                default: state_q <= FBR_IDLE;
            endcase

`ifdef FIFO_BURST_RD_TIMEOUT_EN
            // Saturate at the last count so a lagging zero word count just waits.
            if (state_q != FBR_IDLE || i_emp || full_go || tmo_go) begin
                tmr_q <= '0;
            end else if (tmr_q != TMR_LAST) begin
                tmr_q <= tmr_q + 1'b1;
            end
`endif
        end
    end

    assign o_val  = val_q;
    assign o_dat  = dat_q;
    assign o_sop  = sop_q;
    assign o_eop  = eop_q;
    assign o_len  = len_q;
    assign o_busy = (state_q == FBR_BURST);

endmodule

// File: tb/tb_fifo_burst_rd.sv
// tb/tb_fifo_burst_rd.sv - directed self-checking bench for fifo_burst_rd
module tb_fifo_burst_rd;

    localparam int DW = 8;
    localparam int CW = 4;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_val;
    logic [DW-1:0] i_dat;
    logic          o_rdy;
    logic          i_emp;
    logic [CW-1:0] i_wrds;
    logic          o_val;
    logic [DW-1:0] o_dat;
    logic          o_sop;
    logic          o_eop;
    logic [CW-1:0] o_len;
    logic          i_rdy;
    logic          o_busy;

    fifo_burst_rd #(
        .DAT_BITS   (DW),
        .CNT_BITS   (CW),
        .BURST_LEN  (BL),
        .TIMEOUT_CYC(64)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(i_rst_n),
        .i_val  (i_val),
        .i_dat  (i_dat),
        .o_rdy  (o_rdy),
        .i_emp  (i_emp),
        .i_wrds (i_wrds),
        .o_val  (o_val),
        .o_dat  (o_dat),
        .o_sop  (o_sop),
        .o_eop  (o_eop),
        .o_len  (o_len),
        .i_rdy  (i_rdy),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] bd[$];
    logic          bs[$];
    logic          be[$];
    logic [CW-1:0] bl[$];
    int            bc[$];

    int   cyc       = 0;
    int   pops      = 0;
    int   val_hold  = 0;
    bit   uf_arm    = 0;
    int   uf_at     = 0;
    bit   pat_en    = 0;
    int   pat_idx   = 0;
    logic pat[4]    = '{1'b1, 1'b0, 1'b0, 1'b1};

    bit            stall_prev = 0;
    logic [DW-1:0] prev_dat;
    logic          prev_sop;
    logic          prev_eop;
    logic [CW-1:0] prev_len;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        i_val  = (fq.size() != 0) && (val_hold == 0);
        if (val_hold > 0) val_hold--;
        i_dat  = (fq.size() != 0) ? fq[0] : '0;
        i_emp  = (fq.size() == 0);
        i_wrds = CW'(fq.size());
        i_rdy  = pat_en ? pat[pat_idx % 4] : 1'b1;
        pat_idx++;
    endtask

    task automatic step();
        logic pop_now;
        @(negedge clk);
        cyc++;
        pop_now = i_val && o_rdy;
        if (stall_prev) begin
            chk("hold_dat", o_dat, prev_dat);
            chk("hold_sop", o_sop, prev_sop);
            chk("hold_eop", o_eop, prev_eop);
            chk("hold_len", o_len, prev_len);
        end
        if (o_val && i_rdy) begin
            bd.push_back(o_dat);
            bs.push_back(o_sop);
            be.push_back(o_eop);
            bl.push_back(o_len);
            bc.push_back(cyc);
        end
        stall_prev = o_val && !i_rdy;
        prev_dat   = o_dat;
        prev_sop   = o_sop;
        prev_eop   = o_eop;
        prev_len   = o_len;
        @(posedge clk);
        #1;
        if (pop_now && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
            if (uf_arm && pops == uf_at) begin
                val_hold = 3;
                uf_arm   = 0;
            end
        end
        drive();
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
        drive();
    endtask

    task automatic clear_logs();
        bd.delete(); bs.delete(); be.delete(); bl.delete(); bc.delete();
        pops = 0;
    endtask

    task automatic run_beats(input string tag, input int n, input int budget);
        int k = 0;
        while (bd.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, bd.size(), n);
    endtask

    task automatic chk_burst(input string tag, input int off, input int n, input logic [DW-1:0] base);
        if (bd.size() >= off + n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "_dat"}, bd[off+i], base + DW'(i));
                chk({tag, "_sop"}, bs[off+i], (i == 0));
                chk({tag, "_eop"}, be[off+i], (i == n - 1));
                chk({tag, "_len"}, bl[off+i], n);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_val"},  o_val,  0);
        chk({tag, "_rdy"},  o_rdy,  0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_sop"},  o_sop,  0);
        chk({tag, "_eop"},  o_eop,  0);
        chk({tag, "_dat"},  o_dat,  0);
        chk({tag, "_len"},  o_len,  0);
    endtask

    initial begin
        int n_eop;
        i_rst_n = 1'b0;
        drive();
        repeat (3) step();
        chk_all_zero("rst");
        i_rst_n = 1'b1;
        step();

        // 1: threshold
        clear_logs();
        push_words(8'h10, 3);
        repeat (10) step();
        chk("t1_wait_beats", bd.size(), 0);
        chk("t1_wait_busy", o_busy, 0);
        chk("t1_wait_pops", pops, 0);
        push_words(8'h13, 1);
        run_beats("t1_beats", 4, 40);
        chk_burst("t1", 0, 4, 8'h10);
        repeat (3) step();
        chk("t1_pops", pops, 4);
        chk("t1_idle", o_busy, 0);

        // 2: backpressure
        clear_logs();
        pat_en  = 1;
        pat_idx = 0;
        push_words(8'h20, 4);
        run_beats("t2_beats", 4, 80);
        chk_burst("t2", 0, 4, 8'h20);
        pat_en = 0;
        repeat (3) step();
        chk("t2_pops", pops, 4);

        // 3: mid-burst underflow
        clear_logs();
        uf_arm = 1;
        uf_at  = 2;
        push_words(8'h30, 4);
        run_beats("t3_beats", 4, 60);
        chk_burst("t3", 0, 4, 8'h30);
        if (bc.size() >= 4) chk("t3_bubble", (bc[3] - bc[0]) >= 6, 1);
        repeat (5) step();
        chk("t3_pops", pops, 4);
        n_eop = 0;
        foreach (be[i]) if (be[i]) n_eop++;
        chk("t3_eops", n_eop, 1);

        // 4: back-to-back bursts
        clear_logs();
        push_words(8'h40, 8);
        run_beats("t4_beats", 8, 80);
        chk_burst("t4a", 0, 4, 8'h40);
        chk_burst("t4b", 4, 4, 8'h44);
        if (bc.size() >= 5) chk("t4_gap", (bc[4] - bc[3]) >= 2, 1);
        repeat (3) step();
        chk("t4_pops", pops, 8);

        // 5: reset mid-burst
        clear_logs();
        push_words(8'h50, 4);
        run_beats("t5_pre", 2, 40);
        i_rst_n = 1'b0;
        step();
        chk_all_zero("t5_rst");
        fq.delete();
        drive();
        i_rst_n    = 1'b1;
        stall_prev = 0;
        step();
        clear_logs();
        push_words(8'h60, 4);
        run_beats("t5_beats", 4, 40);
        chk_burst("t5", 0, 4, 8'h60);
        repeat (3) step();

        // 6: residual words
        clear_logs();
        push_words(8'h70, 2);
`ifdef FIFO_BURST_RD_TIMEOUT_EN
        run_beats("t6_beats", 2, 120);
        chk_burst("t6", 0, 2, 8'h70);
        if (bc.size() >= 1) chk("t6_late", bc[0] >= 64, 1);
`else
        repeat (100) step();
        chk("t6_beats", bd.size(), 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_pops", pops, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
